stream_width_serializer: RTL and testbench
==========================================

// Module: stream_width_serializer
// PURPOSE
//   Downstream neighbour of the compressor output FIFO. Consumes the 256-bit
//   compressed words and serializes each into OUT_W-bit beats, least
//   significant slice first, for the narrower host/DMA stream interface.
//   Preserves packet framing: tlast on an input word maps to the final beat.
//   Reports the beat length of every completed packet.
// PARAMETERS
//   IN_W        256  input word width (DATA_WIDTH * NUM_DATA)
//   OUT_W       64   output beat width; IN_W must be an integer multiple
//   NUM_SLICES  4    IN_W / OUT_W, derived; must be >= 2
//   CNT_W       16   width of the packet beat counter
// PORTS
//   clk         in   1          rising-edge clock
//   reset       in   1          asynchronous, active-low reset
//   wrt_en      in   1          global enable; 0 freezes all state
//   data_in     in   IN_W       compressed word from upstream
//   tvalid_in   in   1          data_in valid
//   tlast_in    in   1          data_in is last word of the packet
//   tready_out  out  1          this block accepts data_in this cycle
//   data_out    out  OUT_W      current output beat
//   tvalid_out  out  1          data_out valid
//   tlast_out   out  1          data_out is last beat of the packet
//   tready_in   in   1          downstream accepts data_out this cycle
//   pkt_len     out  CNT_W      beat count of the last completed packet
//   pkt_done    out  1          one-cycle pulse when pkt_len updates
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, hold_reg=0, hold_last=0, idx=0,
//   beat_cnt=0, pkt_len=0, pkt_done=0, tvalid_out=0, tlast_out=0,
//   data_out=0, tready_out=0. Any in-flight word is discarded.
// - Handshakes: in_xfer = tvalid_in & tready_out;
//   out_xfer = tvalid_out & tready_in.
// - FSM: IDLE (no word held), SEND (hold_reg valid, idx = slice presented).
//   IDLE -> SEND on in_xfer: hold_reg<=data_in, hold_last<=tlast_in, idx<=0.
//   SEND, out_xfer, idx<NUM_SLICES-1: idx<=idx+1.
//   SEND, out_xfer, idx==NUM_SLICES-1, tvalid_in: reload hold_reg, idx<=0,
//   stay SEND (zero-bubble back-to-back words).
//   SEND, out_xfer, idx==NUM_SLICES-1, !tvalid_in: -> IDLE.
// - tready_out = wrt_en & (IDLE | (SEND & idx==NUM_SLICES-1 & tready_in)).
//   Combinational from registered state and tready_in.
// - tvalid_out = (state==SEND); data_out = hold_reg[idx*OUT_W +: OUT_W];
//   tlast_out = hold_last & (idx==NUM_SLICES-1). All three are driven
//   from registers only.
// - Latency: word accepted in cycle N; slice 0 is on data_out in N+1.
//   Throughput: one beat per cycle, i.e. NUM_SLICES cycles per word.
// - Stability: while tvalid_out & !tready_in, data_out/tlast_out hold.
// - Counter: beat_cnt increments on each out_xfer and saturates at
//   2^CNT_W-1. On an out_xfer with tlast_out=1:
//   pkt_len<=beat_cnt+1 (saturating), pkt_done<=1, beat_cnt<=0.
//   pkt_done is 0 in every other cycle.
// - wrt_en==0: no register changes, tready_out=0, outputs hold their
//   values; tvalid_out may remain 1, and downstream must not treat
//   tready_in as consumed (no out_xfer is honoured while wrt_en==0).
// - Packets without tlast keep accumulating beat_cnt (saturating). tvalid_in
//   while tready_out=0 is ignored; upstream must hold data_in.
// TESTING
// 1 Single word 0x..04_03_02_01 (slices 1..4), tlast_in=1, tready_in=1 ->
//   beats 1,2,3,4 on 4 consecutive cycles, tlast only on beat 4;
//   pkt_len=4 and pkt_done pulse in the cycle after beat 4.
// 2 Three back-to-back words, tvalid_in held high, last word tlast ->
//   12 contiguous beats with no gap, tready_out high once per 4 cycles;
//   pkt_len=12.
// 3 tready_in toggling 1,0,0,1,... during a word -> every slice appears
//   exactly once, in order, stable while stalled; no loss or duplication.
// 4 reset asserted low mid-word (after beat 2) -> tvalid_out=0 immediately
//   (async); after release a new 1-word packet yields 4 beats and pkt_len=4.
// 5 wrt_en=0 for 5 cycles during beat 3 with tready_in=1 -> idx frozen,
//   tready_out=0; resumes at beat 3 when wrt_en=1.
// 6 CNT_W=4 with a 5-word packet (20 beats) -> pkt_len saturates at 15.

Source files
------------

// File: rtl/stream_width_serializer.sv
// Purpose : slices each IN_W-bit word into NUM_SLICES OUT_W-bit beats (LSB slice first), keeps tlast framing, reports packet beat length.
// Latency : word accepted in cycle N presents slice 0 in N+1; one beat per cycle, zero bubble between back-to-back words.
// Backpress: tready_out only while idle or while the final slice is leaving; wrt_en=0 freezes everything and honours no transfer.
//
// Ports:
//   clk, reset (async, active-low), wrt_en (global freeze when 0)
//   data_in/tvalid_in/tlast_in/tready_out : upstream word stream
//   data_out/tvalid_out/tlast_out/tready_in : downstream beat stream
//   pkt_len/pkt_done : beat count of the last completed packet, one-cycle update pulse
module stream_width_serializer #(
   parameter int IN_W       = 256,
   parameter int OUT_W      = 64,
   parameter int NUM_SLICES = IN_W / OUT_W,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wrt_en,
   input  logic [IN_W-1:0]   data_in,
   input  logic              tvalid_in,
   input  logic              tlast_in,
   output logic              tready_out,
   output logic [OUT_W-1:0]  data_out,
   output logic              tvalid_out,
   output logic              tlast_out,
   input  logic              tready_in,
   output logic [CNT_W-1:0]  pkt_len,
   output logic              pkt_done
);

   localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [0:0]                        state;
   logic [NUM_SLICES-1:0][OUT_W-1:0]  hold_reg;
   logic                              hold_last;
   logic [IDX_W-1:0]                  idx;
   logic [CNT_W-1:0]                  beat_cnt;

   logic last_slice;
   logic in_xfer;
   logic out_xfer;

   assign last_slice = (idx == LAST_IDX);

   // Outputs come straight from the holding register, so they stay put
   // for as long as downstream stalls.
   assign tvalid_out = (state == ST_SEND);
   assign data_out   = hold_reg[idx];
   assign tlast_out  = hold_last & last_slice;

   // A new word is taken only when the holding register is free, or is
   // freed in this very cycle by the last slice leaving. Gated by reset so
   // nothing is offered upstream while the block is held in reset.
   assign tready_out = reset & wrt_en &
                       ((state == ST_IDLE) |
                        ((state == ST_SEND) & last_slice & tready_in));

   assign in_xfer  = tvalid_in & tready_out;
   // tready_in is not consumed while frozen.
   assign out_xfer = wrt_en & tvalid_out & tready_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         hold_reg  <= '0;
         hold_last <= 1'b0;
         idx       <= '0;
         beat_cnt  <= '0;
         pkt_len   <= '0;
         pkt_done  <= 1'b0;
      end else if (wrt_en) begin
         pkt_done <= 1'b0;

         if (out_xfer) begin
            if (tlast_out) begin
               // Count includes the beat leaving now; both saturate.
               pkt_len  <= (beat_cnt == CNT_MAX) ? CNT_MAX : beat_cnt + 1'b1;
               pkt_done <= 1'b1;
               beat_cnt <= '0;
            end else if (beat_cnt != CNT_MAX) begin
               beat_cnt <= beat_cnt + 1'b1;
            end

            if (!last_slice) begin
               idx <= idx + 1'b1;
            end
         end

         // Reload takes priority: covers both IDLE pickup and the
         // back-to-back case where the last slice leaves this cycle.
         if (in_xfer) begin
            hold_reg  <= data_in;
            hold_last <= tlast_in;
            idx       <= '0;
            state     <= ST_SEND;
         end else if (out_xfer && last_slice) begin
            state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_stream_width_serializer.sv
module tb_stream_width_serializer;

   localparam int IN_W  = 256;
   localparam int OUT_W = 64;
   localparam int NS    = IN_W / OUT_W;

   typedef struct {
      logic [OUT_W-1:0] dat;
      logic             last;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              wrt_en;
   logic [IN_W-1:0]   data_in;
   logic              tvalid_in;
   logic              tlast_in;
   logic              tready_in;

   logic              tready_out;
   logic [OUT_W-1:0]  data_out;
   logic              tvalid_out;
   logic              tlast_out;
   logic [15:0]       pkt_len;
   logic              pkt_done;

   logic              tready_out_4;
   logic [OUT_W-1:0]  data_out_4;
   logic              tvalid_out_4;
   logic              tlast_out_4;
   logic [3:0]        pkt_len_4;
   logic              pkt_done_4;

   int vectors     = 0;
   int miscompares = 0;

   beat_t exp_q[$];
   int    cyc        = 0;
   int    pkt_beats  = 0;
   int    first_cyc  = 0;
   int    span       = 0;
   int    exp_len    = 0;
   logic  pend_done  = 1'b0;
   logic  prev_stall = 1'b0;
   logic [OUT_W-1:0] prev_dat;
   logic  prev_last;

   always #5 clk = ~clk;

   stream_width_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .wrt_en(wrt_en),
      .data_in(data_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in),
      .tready_out(tready_out),
      .data_out(data_out), .tvalid_out(tvalid_out), .tlast_out(tlast_out),
      .tready_in(tready_in),
      .pkt_len(pkt_len), .pkt_done(pkt_done)
   );

   stream_width_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .wrt_en(wrt_en),
      .data_in(data_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in),
      .tready_out(tready_out_4),
      .data_out(data_out_4), .tvalid_out(tvalid_out_4), .tlast_out(tlast_out_4),
      .tready_in(tready_in),
      .pkt_len(pkt_len_4), .pkt_done(pkt_done_4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor: samples at the falling edge, when inputs and outputs are settled
   // for the coming rising edge.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         exp_q.delete();
         pkt_beats  = 0;
         pend_done  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         chk("pkt_done", 64'(pkt_done), 64'(pend_done));
         if (pend_done) begin
            chk("pkt_len", 64'(pkt_len), 64'(exp_len));
            chk("pkt_len_sat", 64'(pkt_len_4), 64'((exp_len > 15) ? 15 : exp_len));
         end
         if (prev_stall && tvalid_out) begin
            chk("stall_dat", data_out, prev_dat);
            chk("stall_last", 64'(tlast_out), 64'(prev_last));
         end
         prev_stall = tvalid_out && !(tready_in && wrt_en);
         prev_dat   = data_out;
         prev_last  = tlast_out;

         if (wrt_en) pend_done = 1'b0;
         if (wrt_en && tvalid_out && tready_in) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("beat_dat", data_out, b.dat);
               chk("beat_last", 64'(tlast_out), 64'(b.last));
               if (pkt_beats == 0) first_cyc = cyc;
               pkt_beats++;
               if (b.last) begin
                  exp_len   = pkt_beats;
                  span      = cyc - first_cyc;
                  pkt_beats = 0;
                  pend_done = 1'b1;
               end
            end
         end
         if (wrt_en && tvalid_in && tready_out) begin
            for (int s = 0; s < NS; s++) begin
               beat_t b;
               b.dat  = data_in[s*OUT_W +: OUT_W];
               b.last = tlast_in && (s == NS - 1);
               exp_q.push_back(b);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [IN_W-1:0] w, input logic last, input logic keep);
      int n = 0;
      data_in   = w;
      tlast_in  = last;
      tvalid_in = 1'b1;
      while (tready_out !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("accept_timeout", 64'(n < 100), 64'd1);
      step();
      if (!keep) begin
         tvalid_in = 1'b0;
         tlast_in  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((tvalid_out || exp_q.size() != 0) && n < 200) begin
         step();
         n++;
      end
      chk("idle_timeout", 64'(n < 200), 64'd1);
   endtask

   function automatic logic [IN_W-1:0] rnd_word();
      logic [IN_W-1:0] w;
      for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   initial begin
      logic [IN_W-1:0] w;
      logic [3:0]      pat;

      reset     = 1'b0;
      wrt_en    = 1'b1;
      data_in   = '0;
      tvalid_in = 1'b0;
      tlast_in  = 1'b0;
      tready_in = 1'b1;
      repeat (3) step();

      // Reset state
      chk("rst_tvalid", 64'(tvalid_out), 64'd0);
      chk("rst_tready", 64'(tready_out), 64'd0);
      chk("rst_tlast", 64'(tlast_out), 64'd0);
      chk("rst_data", data_out, 64'd0);
      chk("rst_pkt_len", 64'(pkt_len), 64'd0);
      chk("rst_pkt_done", 64'(pkt_done), 64'd0);
      reset = 1'b1;
      step();
      chk("idle_tready", 64'(tready_out), 64'd1);

      // 1: single word, slices 1..4
      w = {64'd4, 64'd3, 64'd2, 64'd1};
      send_word(w, 1'b1, 1'b0);
      chk("t1_latency_vld", 64'(tvalid_out), 64'd1);
      chk("t1_latency_dat", data_out, 64'd1);
      chk("t1_first_last", 64'(tlast_out), 64'd0);
      repeat (4) step();
      chk("t1_pkt_done", 64'(pkt_done), 64'd1);
      chk("t1_pkt_len", 64'(pkt_len), 64'd4);
      chk("t1_idle", 64'(tvalid_out), 64'd0);

      // 2: three back-to-back words
      send_word(rnd_word(), 1'b0, 1'b1);
      send_word(rnd_word(), 1'b0, 1'b1);
      send_word(rnd_word(), 1'b1, 1'b0);
      wait_idle();
      chk("t2_pkt_len", 64'(pkt_len), 64'd12);
      chk("t2_no_gap_span", 64'(span), 64'd11);

      // 3: downstream toggling 1,0,0,1
      pat = 4'b1001;
      tready_in = 1'b0;
      send_word(rnd_word(), 1'b1, 1'b0);
      for (int i = 0; i < 24; i++) begin
         tready_in = pat[i % 4];
         step();
      end
      tready_in = 1'b1;
      wait_idle();
      chk("t3_pkt_len", 64'(pkt_len), 64'd4);

      // 5: freeze during beat 3
      w = rnd_word();
      send_word(w, 1'b1, 1'b0);
      step();
      step();
      chk("t5_beat3", data_out, w[2*OUT_W +: OUT_W]);
      wrt_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_frozen_dat", data_out, w[2*OUT_W +: OUT_W]);
         chk("t5_frozen_rdy", 64'(tready_out), 64'd0);
         chk("t5_frozen_vld", 64'(tvalid_out), 64'd1);
      end
      wrt_en = 1'b1;
      chk("t5_resume_dat", data_out, w[2*OUT_W +: OUT_W]);
      step();
      chk("t5_next_dat", data_out, w[3*OUT_W +: OUT_W]);
      wait_idle();
      chk("t5_pkt_len", 64'(pkt_len), 64'd4);

      // 4: async reset mid-word
      send_word(rnd_word(), 1'b1, 1'b0);
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("t4_async_vld", 64'(tvalid_out), 64'd0);
      chk("t4_async_rdy", 64'(tready_out), 64'd0);
      chk("t4_async_len", 64'(pkt_len), 64'd0);
      step();
      step();
      reset = 1'b1;
      step();
      send_word(rnd_word(), 1'b1, 1'b0);
      wait_idle();
      chk("t4_pkt_len", 64'(pkt_len), 64'd4);

      // 6: 20-beat packet, 4-bit counter saturates
      for (int i = 0; i < 5; i++) send_word(rnd_word(), (i == 4), (i != 4));
      wait_idle();
      chk("t6_pkt_len16", 64'(pkt_len), 64'd20);
      chk("t6_pkt_len4", 64'(pkt_len_4), 64'd15);

      repeat (3) step();
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
